// File: rtl/ice_mem_mmio_if.sv
// CPU data-port bus for ice_mem_mmio: one read channel with registered response, one byte-enabled write channel.
interface ice_mem_mmio_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_be,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/ice_mem_mmio.sv
// Data memory with LED/BTN/CNT/CMP registers in the top four words and a sticky timer IRQ.
// Define ICE_MEM_RDW_BYPASS_EN to make same-address RAM read-during-write return the merged new word.
module ice_mem_mmio #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LED_W  = 5,
  parameter int BTN_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  ice_mem_mmio_if.slave    bus,
  output logic [LED_W-1:0] leds,
  input  logic [BTN_W-1:0] btn_in,
  output logic             irq
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  localparam logic [ADDR_W-1:0] A_LED = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] A_BTN = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] A_CNT = ADDR_W'(DEPTH - 3);
  localparam logic [ADDR_W-1:0] A_CMP = ADDR_W'(DEPTH - 4);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] cnt, cmp;
  logic [DATA_W-1:0] cnt_inc, cnt_next, ram_q, rd_sel;
  logic [BTN_W-1:0]  btn_s1, btn_s2;
  logic              wr_any, wr_led, wr_cnt, wr_cmp;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++)
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  assign wr_any = bus.wr_en && (|bus.wr_be);
  assign wr_led = wr_any && (bus.wr_addr == A_LED);
  assign wr_cnt = wr_any && (bus.wr_addr == A_CNT);
  assign wr_cmp = wr_any && (bus.wr_addr == A_CMP);

  // Unwritten CNT lanes carry the incremented value; written lanes take the data as-is.
  assign cnt_inc  = cnt + DATA_W'(1);
  assign cnt_next = wr_cnt ? lane_merge(cnt_inc, bus.wr_data, bus.wr_be) : cnt_inc;

`ifdef ICE_MEM_RDW_BYPASS_EN
  assign ram_q = (bus.wr_en && (bus.wr_addr == bus.rd_addr))
               ? lane_merge(mem[bus.rd_addr], bus.wr_data, bus.wr_be)
               : mem[bus.rd_addr];
`else
  assign ram_q = mem[bus.rd_addr];
`endif

  always_comb begin
    rd_sel = ram_q;
    case (bus.rd_addr)
      A_LED:   rd_sel = DATA_W'(leds);
      A_BTN:   rd_sel = DATA_W'(btn_s2);
      A_CNT:   rd_sel = cnt;
      A_CMP:   rd_sel = cmp;
      default: rd_sel = ram_q;
    endcase
  end

  // RAM is never cleared, but a write coinciding with reset is still suppressed.
  always_ff @(posedge clk) begin
    if (!reset && bus.wr_en) begin
      for (int k = 0; k < NB; k++)
        if (bus.wr_be[k]) mem[bus.wr_addr][8*k +: 8] <= bus.wr_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      leds         <= '0;
      cnt          <= '0;
      cmp          <= '0;
      irq          <= 1'b0;
      btn_s1       <= '0;
      btn_s2       <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_sel;
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
      cnt    <= cnt_next;
      if (wr_led) begin
        for (int i = 0; i < LED_W; i++)
          if (bus.wr_be[i/8]) leds[i] <= bus.wr_data[i];
      end
      if (wr_cmp) cmp <= lane_merge(cmp, bus.wr_data, bus.wr_be);
      // A CMP write clears the IRQ even if the compare matches at the same edge.
      if (wr_cmp)                                  irq <= 1'b0;
      else if ((cmp != '0) && (cnt_next == cmp))   irq <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ice_mem_mmio.sv
// Self-checking bench for ice_mem_mmio: directed vectors plus a per-cycle reference model of the memory map.
module tb_ice_mem_mmio;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LED_W  = 5;
  localparam int BTN_W  = 4;
  localparam logic [7:0] A_LED = 8'hFF;
  localparam logic [7:0] A_BTN = 8'hFE;
  localparam logic [7:0] A_CNT = 8'hFD;
  localparam logic [7:0] A_CMP = 8'hFC;

  logic             clk = 1'b0;
  logic             reset;
  logic [LED_W-1:0] leds;
  logic [BTN_W-1:0] btn_in;
  logic             irq;

  ice_mem_mmio_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ice_mem_mmio #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LED_W(LED_W), .BTN_W(BTN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus.slave),
    .leds   (leds),
    .btn_in (btn_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the given bus request; returns 1 time unit after the edge.
  task automatic applyStimulus(input bit re, input logic [7:0] ra, input bit we,
                               input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be);
    bus.rd_en   = re;
    bus.rd_addr = ra;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_be   = be;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Reference model: memory-map state as plain variables, updated once per rising edge.
  bit          m_ready = 1'b0;
  logic [31:0] m_ram [256];
  logic [4:0]  m_led;
  logic [31:0] m_cnt, m_cmp, m_rd_data;
  logic        m_irq, m_rd_valid;
  logic [3:0]  m_b1, m_b2;

  initial for (int i = 0; i < 256; i++) m_ram[i] = 32'h0;

  always @(posedge clk) begin : model
    logic [31:0] mask, c_new, rd_val, tmp;
    if (reset) begin
      m_ready = 1'b1;
      m_led = '0; m_cnt = '0; m_cmp = '0; m_irq = 1'b0;
      m_b1 = '0; m_b2 = '0; m_rd_data = '0; m_rd_valid = 1'b0;
    end else begin
      mask = bus.wr_en ? be_mask(bus.wr_be) : 32'h0;
      if (bus.rd_en) begin
        if      (bus.rd_addr == A_LED) rd_val = {27'b0, m_led};
        else if (bus.rd_addr == A_BTN) rd_val = {28'b0, m_b2};
        else if (bus.rd_addr == A_CNT) rd_val = m_cnt;
        else if (bus.rd_addr == A_CMP) rd_val = m_cmp;
        else begin
          rd_val = m_ram[bus.rd_addr];
`ifdef ICE_MEM_RDW_BYPASS_EN
          if (bus.wr_addr == bus.rd_addr) rd_val = (rd_val & ~mask) | (bus.wr_data & mask);
`endif
        end
        m_rd_data = rd_val;
      end
      m_rd_valid = bus.rd_en;
      c_new = m_cnt + 32'd1;
      if (bus.wr_addr == A_CNT) c_new = (c_new & ~mask) | (bus.wr_data & mask);
      if (bus.wr_addr == A_CMP && mask != 0)       m_irq = 1'b0;
      else if (m_cmp != 0 && c_new == m_cmp)       m_irq = 1'b1;
      if (bus.wr_addr == A_CMP) m_cmp = (m_cmp & ~mask) | (bus.wr_data & mask);
      if (bus.wr_addr == A_LED) begin
        tmp   = ({27'b0, m_led} & ~mask) | (bus.wr_data & mask);
        m_led = tmp[4:0];
      end
      if (bus.wr_addr < A_CMP)
        m_ram[bus.wr_addr] = (m_ram[bus.wr_addr] & ~mask) | (bus.wr_data & mask);
      m_cnt = c_new;
      m_b2  = m_b1;
      m_b1  = btn_in;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      checkOutput("model_rd_valid", {31'b0, bus.rd_valid}, {31'b0, m_rd_valid});
      checkOutput("model_rd_data", bus.rd_data, m_rd_data);
      checkOutput("model_leds", {27'b0, leds}, {27'b0, m_led});
      checkOutput("model_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  initial begin
    int rise;
    reset       = 1'b1;
    btn_in      = 4'h0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_be   = '0;

    // Reset state, then a CNT read right after release
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    checkOutput("reset_leds", {27'b0, leds}, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    checkOutput("reset_rd_data", bus.rd_data, 32'h0);
    reset = 1'b0;
    applyStimulus(1, A_CNT, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("cnt_read_valid", {31'b0, bus.rd_valid}, 32'h1);
    checkOutput("cnt_small_after_reset", {31'b0, (bus.rd_data <= 32'd3)}, 32'h1);
    applyStimulus(0, 8'h00, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("rd_valid_idle", {31'b0, bus.rd_valid}, 32'h0);

    // RAM byte-enabled writes
    applyStimulus(0, 8'h00, 1, 8'h10, 32'hAABBCCDD, 4'b1111);
    applyStimulus(0, 8'h00, 1, 8'h10, 32'h11223344, 4'b0101);
    applyStimulus(1, 8'h10, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("ram_be_valid", {31'b0, bus.rd_valid}, 32'h1);
    checkOutput("ram_be_data", bus.rd_data, 32'hAA22CC44);
    applyStimulus(0, 8'h00, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("rd_data_hold", bus.rd_data, 32'hAA22CC44);

    // LED register
    applyStimulus(0, 8'h00, 1, A_LED, 32'h1F, 4'b1111);
    checkOutput("led_1f", {27'b0, leds}, 32'h1F);
    applyStimulus(0, 8'h00, 1, A_LED, 32'h2A, 4'b1111);
    checkOutput("led_2a", {27'b0, leds}, 32'h0A);
    applyStimulus(0, 8'h00, 1, A_LED, 32'h1F, 4'b0000);
    checkOutput("led_be_zero_noop", {27'b0, leds}, 32'h0A);
    applyStimulus(1, A_LED, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("led_readback", bus.rd_data, 32'h0A);

    // Timer compare and sticky IRQ
    applyStimulus(0, 8'h00, 1, A_CMP, 32'd20, 4'b1111);
    applyStimulus(0, 8'h00, 1, A_CNT, 32'd0, 4'b1111);
    checkOutput("irq_before_match", {31'b0, irq}, 32'h0);
    rise = 0;
    for (int i = 1; i <= 40 && rise == 0; i++) begin
      applyStimulus(0, 8'h00, 0, 8'h00, 32'h0, 4'h0);
      if (irq) rise = i;
    end
    checkOutput("irq_rise_cycle", rise, 32'd20);
    repeat (3) applyStimulus(0, 8'h00, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("irq_sticky", {31'b0, irq}, 32'h1);
    applyStimulus(0, 8'h00, 1, A_CMP, 32'd0, 4'b1111);
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);

    // Read-during-write: RAM and CNT
    applyStimulus(0, 8'h00, 1, 8'h20, 32'h0, 4'b1111);
    applyStimulus(1, 8'h20, 1, 8'h20, 32'h12345678, 4'b1111);
`ifdef ICE_MEM_RDW_BYPASS_EN
    checkOutput("ram_rdw", bus.rd_data, 32'h12345678);
`else
    checkOutput("ram_rdw", bus.rd_data, 32'h00000000);
`endif
    applyStimulus(1, 8'h20, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("ram_after_rdw", bus.rd_data, 32'h12345678);
    applyStimulus(0, 8'h00, 1, A_CNT, 32'h50, 4'b1111);
    applyStimulus(0, 8'h00, 0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1, A_CNT, 1, A_CNT, 32'h100, 4'b1111);
    checkOutput("cnt_rdw_prewrite", bus.rd_data, 32'h51);
    applyStimulus(1, A_CNT, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("cnt_loaded_no_inc", bus.rd_data, 32'h100);
    applyStimulus(0, 8'h00, 1, A_CNT, 32'hAB00, 4'b0010);
    applyStimulus(1, A_CNT, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("cnt_partial_lane", bus.rd_data, 32'hAB02);

    // Buttons: two-stage synchroniser, writes ignored
    btn_in = 4'b1010;
    applyStimulus(0, 8'h00, 0, 8'h00, 32'h0, 4'h0);
    applyStimulus(0, 8'h00, 1, A_BTN, 32'hF, 4'b1111);
    applyStimulus(1, A_BTN, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("btn_read", bus.rd_data, 32'hA);
    btn_in = 4'b0101;
    applyStimulus(0, 8'h00, 0, 8'h00, 32'h0, 4'h0);
    applyStimulus(1, A_BTN, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("btn_latency", bus.rd_data, 32'hA);

    // Reset coinciding with a read drops the result
    reset = 1'b1;
    applyStimulus(1, A_BTN, 0, 8'h00, 32'h0, 4'h0);
    checkOutput("reset_mid_read_valid", {31'b0, bus.rd_valid}, 32'h0);
    checkOutput("reset_mid_read_data", bus.rd_data, 32'h0);
    checkOutput("reset_mid_read_leds", {27'b0, leds}, 32'h0);
    reset = 1'b0;
    repeat (2) applyStimulus(0, 8'h00, 0, 8'h00, 32'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
